// File: rtl/scratch_mem_arbiter.sv
// scratch_mem_arbiter: shares one single-port scratch memory between a histogram (H) and a CDF (C) requester.
// Latency: grant and memory command in the same cycle as the request; read data returns exactly RD_LAT cycles later.
// Backpressure: a requester that is not granted holds its request; a locked H owner blocks C until lock_h drops.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_h/lock_h/we_h       H request, hold-grant for read-modify-write, write strobe
//   addr_h/wdata_h          H address and write data
//   req_c/addr_c            C read-only request and address
//   gnt_h/gnt_c             access accepted this cycle (never both)
//   rvalid_h/rvalid_c/rdata read return, rdata qualified by the owner's rvalid (0 otherwise)
//   mem_*                   single-port scratch memory with fixed RD_LAT read latency
//   clear_start/clear_busy/clear_done   only when SCRATCH_ARB_CLEAR_EN is defined:
//                           sweeps zeros through every address, one write per cycle
//
// Optional feature macro: SCRATCH_ARB_CLEAR_EN (undefined by default; memory clear engine absent).
module scratch_mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_h,
    input  logic              lock_h,
    input  logic              we_h,
    input  logic [ADDR_W-1:0] addr_h,
    input  logic [DATA_W-1:0] wdata_h,
    input  logic              req_c,
    input  logic [ADDR_W-1:0] addr_c,
    output logic              gnt_h,
    output logic              gnt_c,
    output logic              rvalid_h,
    output logic              rvalid_c,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef SCRATCH_ARB_CLEAR_EN
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef SCRATCH_ARB_CLEAR_EN
    typedef enum logic [1:0] {IDLE, OWN_H, OWN_C, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWN_H, OWN_C} state_t;
`endif

    state_t            state;
    logic              prio_c;      // 1: C wins the next contested cycle
    logic [ADDR_W-1:0] last_addr;   // memory bus holds its last value when idle
    logic [DATA_W-1:0] last_wdata;
    logic [RD_LAT-1:0] sr_vld;      // in-flight read tracker, one stage per cycle of latency
    logic [RD_LAT-1:0] sr_own;      // owner of each in-flight read: 1 = C, 0 = H

    logic              arb_h;
    logic              arb_c;
    logic              hold_h;
    logic              rd_push;
    logic              clr_wr;
    logic [ADDR_W-1:0] clr_addr;

`ifdef SCRATCH_ARB_CLEAR_EN
    logic              clr_pend;    // clear requested while H held the lock
    logic              clr_done_q;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_go;

    assign clr_wr     = (state == CLEAR) && !reset;
    assign clr_addr   = clr_cnt;
    // A clear never preempts a locked H sequence; it waits for the lock to drop.
    assign clr_go     = (clear_start || clr_pend) && !hold_h;
    assign clear_busy = clr_wr;
    assign clear_done = clr_done_q && !reset;
`else
    assign clr_wr     = 1'b0;
    assign clr_addr   = '0;
`endif

    // Plain round-robin between the two requesters.
    always_comb begin
        if (req_h && req_c) begin
            arb_h = !prio_c;
            arb_c = prio_c;
        end else begin
            arb_h = req_h;
            arb_c = req_c;
        end
    end

    // Grants: a locked H owner takes every cycle it asks for and shuts C out;
    // on the cycle the lock is seen low, ordinary round-robin already applies.
    always_comb begin
        gnt_h = 1'b0;
        gnt_c = 1'b0;
        if (!reset && !clr_wr) begin
            if (state == OWN_H && lock_h) begin
                gnt_h = req_h;
            end else begin
                gnt_h = arb_h;
                gnt_c = arb_c;
            end
        end
    end

    // H keeps (or takes) ownership for the next cycle.
    assign hold_h  = lock_h && (state == OWN_H || gnt_h);
    assign rd_push = (gnt_h && !we_h) || gnt_c;

    // Memory command. C is read-only, so its cycles leave wdata at its last value.
    always_comb begin
        mem_en    = gnt_h || gnt_c || clr_wr;
        mem_we    = (gnt_h && we_h) || clr_wr;
        mem_addr  = last_addr;
        mem_wdata = last_wdata;
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (clr_wr) begin
            mem_addr  = clr_addr;
            mem_wdata = '0;
        end else if (gnt_h) begin
            mem_addr  = addr_h;
            mem_wdata = wdata_h;
        end else if (gnt_c) begin
            mem_addr  = addr_c;
        end
    end

    // Read return: the oldest stage lines up with the memory's fixed latency.
    assign rvalid_h = !reset && sr_vld[RD_LAT-1] && !sr_own[RD_LAT-1];
    assign rvalid_c = !reset && sr_vld[RD_LAT-1] && sr_own[RD_LAT-1];
    assign rdata    = (rvalid_h || rvalid_c) ? mem_rdata : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            sr_vld <= '0;
            sr_own <= '0;
        end else begin
            sr_vld[0] <= rd_push;
            sr_own[0] <= gnt_c;
            for (int i = 1; i < RD_LAT; i++) begin
                sr_vld[i] <= sr_vld[i-1];
                sr_own[i] <= sr_own[i-1];
            end
        end
    end

    // Ownership FSM, round-robin pointer and idle bus hold registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            prio_c     <= 1'b0;
            last_addr  <= '0;
            last_wdata <= '0;
`ifdef SCRATCH_ARB_CLEAR_EN
            clr_pend   <= 1'b0;
            clr_cnt    <= '0;
            clr_done_q <= 1'b0;
`endif
        end else begin
            if (gnt_h) begin
                prio_c <= 1'b1;
            end else if (gnt_c) begin
                prio_c <= 1'b0;
            end

            if (mem_en) begin
                last_addr  <= mem_addr;
                last_wdata <= mem_wdata;
            end

            if (hold_h) begin
                state <= OWN_H;
            end else if (gnt_c || (state == OWN_C && req_c)) begin
                state <= OWN_C;
            end else begin
                state <= IDLE;
            end

`ifdef SCRATCH_ARB_CLEAR_EN
            // The clear engine overrides the ownership decision above.
            clr_done_q <= 1'b0;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (&clr_cnt) begin
                    state      <= IDLE;
                    clr_done_q <= 1'b1;
                end else begin
                    state <= CLEAR;
                end
            end else if (clr_go) begin
                state    <= CLEAR;
                clr_pend <= 1'b0;
                clr_cnt  <= '0;
            end else if (clear_start) begin
                clr_pend <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// tb_scratch_mem_arbiter: directed scenarios plus randomized H/C traffic against a behavioural model.
// Latency: the memory model returns read data RD_LAT cycles after the command cycle.
// Backpressure: none modelled; requesters simply re-present requests each cycle.
module tb_scratch_mem_arbiter;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int LAT = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_h, lock_h, we_h, req_c;
    logic [AW-1:0] addr_h, addr_c;
    logic [DW-1:0] wdata_h;
    logic          gnt_h, gnt_c, rvalid_h, rvalid_c;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef SCRATCH_ARB_CLEAR_EN
    logic          clear_start = 1'b0;
    logic          clear_busy, clear_done;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    scratch_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_h     (req_h),
        .lock_h    (lock_h),
        .we_h      (we_h),
        .addr_h    (addr_h),
        .wdata_h   (wdata_h),
        .req_c     (req_c),
        .addr_c    (addr_c),
        .gnt_h     (gnt_h),
        .gnt_c     (gnt_c),
        .rvalid_h  (rvalid_h),
        .rvalid_c  (rvalid_c),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef SCRATCH_ARB_CLEAR_EN
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
`endif
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scratch memory: fixed-latency reads, writes applied at the clock edge.
    logic [DW-1:0] mem    [256];
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] pipe   [LAT];
    assign mem_rdata = pipe[LAT-1];

    always @(posedge clock) begin
        logic [DW-1:0] rd;
        rd = (mem_en && !mem_we) ? mem[mem_addr] : 16'hDEAD;
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = rd;
    end

    // Behavioural reference: who should win, what the bus carries, and a queue of
    // pending read returns stamped with the cycle they are due.
    typedef struct {
        int            due;
        bit            own_c;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           q[$];
    int            cyc = 0;
    bit            m_locked = 1'b0;
    bit            m_prio_c = 1'b0;
    logic [AW-1:0] m_last_addr = '0;
    logic [DW-1:0] m_last_wdata = '0;

    always @(negedge clock) begin
        logic          eh, ec, e_en, e_we, e_rvh, e_rvc;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
        rd_t           r;
        e_rvh = 1'b0; e_rvc = 1'b0; e_rd = '0;
        if (reset) begin
            eh = 1'b0; ec = 1'b0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
            q.delete();
            m_locked = 1'b0; m_prio_c = 1'b0; m_last_addr = '0; m_last_wdata = '0;
        end else begin
            if (m_locked && lock_h) begin
                eh = req_h; ec = 1'b0;
            end else if (req_h && req_c) begin
                eh = !m_prio_c; ec = m_prio_c;
            end else begin
                eh = req_h; ec = req_c;
            end
            e_en   = eh | ec;
            e_we   = eh & we_h;
            e_addr = eh ? addr_h : (ec ? addr_c : m_last_addr);
            e_wd   = eh ? wdata_h : m_last_wdata;
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                e_rvh = !r.own_c; e_rvc = r.own_c; e_rd = r.data;
            end
            if (e_en && !e_we) begin
                r.due = cyc + LAT; r.own_c = ec; r.data = shadow[e_addr];
                q.push_back(r);
            end
            if (e_we) shadow[e_addr] = wdata_h;
            if (eh) m_prio_c = 1'b1;
            else if (ec) m_prio_c = 1'b0;
            m_locked = lock_h && (m_locked || eh);
            if (e_en) begin m_last_addr = e_addr; m_last_wdata = e_wd; end
        end
        chk("gnt_h", gnt_h, eh);
        chk("gnt_c", gnt_c, ec);
        chk("one_grant", gnt_h & gnt_c, 1'b0);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("rvalid_h", rvalid_h, e_rvh);
        chk("rvalid_c", rvalid_c, e_rvc);
        chk("rdata", rdata, e_rd);
        cyc++;
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [DW-1:0] rd_val;
        reset = 1'b1;
        req_h = 1'b0; lock_h = 1'b0; we_h = 1'b0; req_c = 1'b0;
        addr_h = '0; addr_c = '0; wdata_h = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'hA000 + 16'(i);
            shadow[i] = mem[i];
        end
        for (int i = 0; i < LAT; i++) pipe[i] = '0;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_gnt_h", gnt_h, 1'b0);
        chk("rst_rvalid_h", rvalid_h, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_rdata", rdata, 16'h0000);

        // Lone H read of 0x12: granted at once, data back exactly LAT cycles later.
        next_cycle();
        req_h = 1'b1; addr_h = 8'h12;
        #1;
        chk("r030_gnt_h", gnt_h, 1'b1);
        chk("r030_mem_en", mem_en, 1'b1);
        chk("r030_mem_addr", mem_addr, 8'h12);
        chk("r030_mem_we", mem_we, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            req_h = 1'b0;
            #1;
            chk("r030_rvalid_h", rvalid_h, k == 3);
            if (k == 3) chk("r030_rdata", rdata, 16'hA012);
        end

        // Fresh reset so the pointer favours H, then both request for 4 cycles.
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            req_h = (k < 4); req_c = (k < 4);
            addr_h = 8'h20 + 8'(k); addr_c = 8'h30 + 8'(k);
            #1;
            if (k < 4) begin
                chk("r031_gnt_h", gnt_h, (k % 2) == 0);
                chk("r031_gnt_c", gnt_c, (k % 2) == 1);
                chk("r031_addr", mem_addr, ((k % 2) == 0) ? 32'h20 + k : 32'h30 + k);
            end
            if (k >= 3 && k < 7) begin
                chk("r031_rvalid_h", rvalid_h, ((k - 3) % 2) == 0);
                chk("r031_rvalid_c", rvalid_c, ((k - 3) % 2) == 1);
                chk("r031_rdata", rdata, (((k - 3) % 2) == 0) ? 32'hA020 + (k - 3) : 32'hA030 + (k - 3));
            end
        end

        // H read-modify-write of 0x05 under lock while C keeps requesting.
        next_cycle();
        req_h = 1'b1; lock_h = 1'b1; we_h = 1'b0; addr_h = 8'h05;
        req_c = 1'b1; addr_c = 8'h77;
        #1;
        chk("r032_rd_gnt_h", gnt_h, 1'b1);
        chk("r032_rd_gnt_c", gnt_c, 1'b0);
        rd_val = '0;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            req_h = 1'b0;
            #1;
            chk("r032_locked_gnt_c", gnt_c, 1'b0);
            if (k == 3) begin
                chk("r032_rvalid_h", rvalid_h, 1'b1);
                chk("r032_rdata", rdata, 16'hA005);
                rd_val = rdata;
            end
        end
        next_cycle();
        req_h = 1'b1; we_h = 1'b1; wdata_h = rd_val + 16'd1;
        #1;
        chk("r032_wr_gnt_h", gnt_h, 1'b1);
        chk("r032_wr_gnt_c", gnt_c, 1'b0);
        chk("r032_wr_we", mem_we, 1'b1);
        chk("r032_wr_data", mem_wdata, 16'hA006);
        next_cycle();
        req_h = 1'b0; we_h = 1'b0; lock_h = 1'b0; addr_c = 8'h05;
        #1;
        chk("r032_release_gnt_c", gnt_c, 1'b1);
        chk("r032_release_addr", mem_addr, 8'h05);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            req_c = 1'b0;
            #1;
            if (k == 3) begin
                chk("r032_rvalid_c", rvalid_c, 1'b1);
                chk("r032_incremented", rdata, 16'hA006);
            end
        end

        // Reset one cycle after a granted read: that read must never return.
        next_cycle();
        req_h = 1'b1; addr_h = 8'h40;
        #1;
        chk("r033_gnt_h", gnt_h, 1'b1);
        next_cycle();
        req_h = 1'b0; reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        chk("r033_gnt_h0", gnt_h, 1'b0);
        chk("r033_gnt_c0", gnt_c, 1'b0);
        chk("r033_mem_en0", mem_en, 1'b0);
        chk("r033_mem_we0", mem_we, 1'b0);
        chk("r033_mem_addr0", mem_addr, 8'h00);
        chk("r033_mem_wdata0", mem_wdata, 16'h0000);
        chk("r033_rdata0", rdata, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            #1;
            chk("r033_no_rvalid_h", rvalid_h, 1'b0);
        end

        // Randomized H/C traffic with occasional locks, writes and resets.
        for (int n = 0; n < 1000; n++) begin
            next_cycle();
            reset   = ($urandom_range(0, 199) == 0);
            req_h   = ($urandom_range(0, 99) < 60);
            req_c   = ($urandom_range(0, 99) < 50);
            lock_h  = ($urandom_range(0, 99) < 30);
            we_h    = ($urandom_range(0, 99) < 30);
            addr_h  = 8'($urandom_range(0, 255));
            addr_c  = 8'($urandom_range(0, 255));
            wdata_h = 16'($urandom);
        end
        next_cycle();
        reset = 1'b0; req_h = 1'b0; req_c = 1'b0; lock_h = 1'b0; we_h = 1'b0;
        repeat (LAT + 3) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scratch_mem_arbiter.md
SCRATCH_MEM_ARBITER -- requirements
Module: scratch_mem_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, scratch memory word width.
REQ-002 Parameter: ADDR_W, 8, scratch memory address width (2^ADDR_W bins).
REQ-003 Parameter: RD_LAT, 3, fixed scratch memory read latency in cycles, range 1-7.
REQ-004 Port: clock  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  reset, synchronous, active-high.
REQ-006 Ports: req_h, lock_h, we_h  in  1 each  histogram requester: request, hold grant for read-modify-write, write strobe.
REQ-007 Ports: addr_h  in  ADDR_W; wdata_h  in  DATA_W  histogram address and write data.
REQ-008 Ports: req_c  in  1; addr_c  in  ADDR_W  CDF requester, read-only.
REQ-009 Ports: gnt_h, gnt_c  out  1  access accepted this cycle.
REQ-010 Ports: rvalid_h, rvalid_c  out  1; rdata  out  DATA_W  read return, qualified by owner's rvalid.
REQ-011 Ports: mem_en, mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  single-port scratch memory.
REQ-012 Ports (only with SCRATCH_ARB_CLEAR_EN): clear_start  in  1; clear_busy, clear_done  out  1.

Function
REQ-013 States SHALL be IDLE, OWN_H, OWN_C, CLEAR; state and pointers registered, grants combinational from state and inputs.
REQ-014 At most one of gnt_h, gnt_c SHALL be high per cycle; granted access drives mem_en=1, mem_addr, mem_we, mem_wdata in the same cycle.
REQ-015 CDF grants SHALL always have mem_we=0; histogram grants pass we_h/wdata_h.
REQ-016 Both requesting, no lock active: grant the requester not granted last (round-robin pointer, reset value favours H).
REQ-017 gnt_h with lock_h=1: IDLE/OWN_C -> OWN_H; while OWN_H and lock_h=1, gnt_c=0 and any req_h is granted.
REQ-018 OWN_H -> IDLE on the cycle lock_h is sampled 0; in that same cycle normal round-robin applies.
REQ-019 OWN_C: entered on gnt_c, left to IDLE when req_c=0; no lock semantics for C (round-robin every cycle).
REQ-020 Each granted read SHALL push {valid, owner} into an RD_LAT-deep shift register; rvalid_<owner> asserted exactly RD_LAT cycles after grant, rdata = mem_rdata that cycle.
REQ-021 Writes SHALL never produce rvalid; back-to-back reads SHALL return at one per cycle in grant order.
REQ-022 No request: mem_en=0, mem_we=0, mem_addr and mem_wdata hold last value.
REQ-023 Simultaneous read and later write to same address by H is the requester's responsibility; arbiter adds no forwarding.

Reset
REQ-024 On reset: state IDLE, pointer favours H, shift register cleared; all outputs 0 (gnt_*, rvalid_*, rdata, mem_*, clear_busy, clear_done).
REQ-025 Reset mid-operation SHALL drop lock, abort clear, and suppress any rvalid for in-flight reads.

Configuration
REQ-026 Macro SCRATCH_ARB_CLEAR_EN defined: clear_start (1-cycle pulse) enters CLEAR when not in OWN_H, else deferred until OWN_H exits; pending flag registered.
REQ-027 CLEAR: clear_busy=1, gnt_*=0, writes 0 to addresses 0..2^ADDR_W-1, one per cycle, mem_we=1; clear_done pulses 1 cycle after last write, then IDLE.
REQ-028 clear_start during CLEAR SHALL be ignored; in-flight reads still return rvalid during CLEAR.
REQ-029 Macro undefined: clear ports, CLEAR state and counter absent; behaviour otherwise identical.

Verification
REQ-030 req_h=1, addr_h=0x12, lock_h=0, we_h=0 alone -> gnt_h same cycle, mem_addr=0x12, rvalid_h exactly 3 cycles later with rdata=mem contents.
REQ-031 req_h=req_c=1 for 4 cycles, no lock -> grants H,C,H,C; rvalid sequence matches, delayed 3.
REQ-032 H RMW: lock_h=1 for read 0x05, 3 idle, write 0x05 +1, req_c=1 throughout -> gnt_c=0 until lock_h drops; mem[0x05] incremented once.
REQ-033 Reset asserted 1 cycle after granted read -> no rvalid_h ever appears; all outputs 0 next cycle.
REQ-034 With SCRATCH_ARB_CLEAR_EN: clear_start while H locked -> CLEAR starts after lock release, 256 writes of 0, clear_done pulse at cycle 257, requests ignored meanwhile.
REQ-035 Without SCRATCH_ARB_CLEAR_EN: random H/C traffic 1000 cycles -> scoreboard match, never two grants in one cycle.
